// File: rtl/lsu_pkg.sv
// Shared types for the load/store alignment sequencer: access sizes, sequencer
// states and the size-to-byte-count helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_ILL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LD2  = 2'b01,
      ST2  = 2'b10
   } state_e;

   // Illegal size maps to zero bytes so it never produces a mask or a split.
   function automatic logic [2:0] size_to_nbytes(input size_e size);
      case (size)
         SZ_B:    size_to_nbytes = 3'd1;
         SZ_H:    size_to_nbytes = 3'd2;
         SZ_W:    size_to_nbytes = 3'd4;
         default: size_to_nbytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: builds the two-word byte-write mask and the shifted
// store data for an access at byte offset i_off.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  i_off,
   input  size_e       i_size,
   input  logic [31:0] i_wdata,
   output logic [7:0]  o_wmask8,
   output logic [63:0] o_wdata64
);

   logic [2:0] nbytes_s;
   logic [7:0] low_mask_s;

   // Mask of nbytes ones moved up to the byte offset; data follows the same shift.
   always_comb begin
      nbytes_s   = size_to_nbytes(i_size);
      low_mask_s = 8'hFF >> (4'd8 - {1'b0, nbytes_s});
      o_wmask8   = low_mask_s << i_off;
      o_wdata64  = {32'h0000_0000, i_wdata} << {i_off, 3'b000};
   end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store sequencer: turns byte-addressed B/H/W accesses into word SRAM
// beats, splitting word-crossing accesses into two beats.
module lsu_align_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [1:0]        i_req_size,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_data,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-3:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   input  logic [31:0]       i_mem_rdata
);

   localparam int WA_W = ADDR_W - 2;

   state_e          state_q, state_d;
   logic [WA_W-1:0] wa1_q, wa1_d;
   logic [1:0]      off_q, off_d;
   logic [31:0]     lo_q, lo_d;
   logic [31:0]     hi_wdata_q, hi_wdata_d;
   logic [3:0]      hi_mask_q, hi_mask_d;
   logic            split_q, split_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            ill_q, ill_d;

   size_e           size_s;
   logic [1:0]      off_s;
   logic [WA_W-1:0] wa_s;
   logic [2:0]      nbytes_s;
   logic            req_split_s;
   logic            accept_s;
   logic [7:0]      wmask8_s;
   logic [63:0]     wdata64_s;
   logic [63:0]     rsp_src_s;
   logic [63:0]     rsp_shift_s;

   assign size_s      = size_e'(i_req_size);
   assign off_s       = i_req_addr[1:0];
   assign wa_s        = i_req_addr[ADDR_W-1:2];
   assign nbytes_s    = size_to_nbytes(size_s);
   assign req_split_s = (({1'b0, off_s} + nbytes_s) > 3'd4);
   assign accept_s    = i_req_valid && o_req_ready;

   lsu_byte_lane u_byte_lane (
      .i_off     (off_s),
      .i_size    (size_s),
      .i_wdata   (i_req_wdata),
      .o_wmask8  (wmask8_s),
      .o_wdata64 (wdata64_s)
   );

   // State and beat/response bookkeeping registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         wa1_q       <= '0;
         off_q       <= 2'b00;
         lo_q        <= 32'h0000_0000;
         hi_wdata_q  <= 32'h0000_0000;
         hi_mask_q   <= 4'b0000;
         split_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wa1_q       <= wa1_d;
         off_q       <= off_d;
         lo_q        <= lo_d;
         hi_wdata_q  <= hi_wdata_d;
         hi_mask_q   <= hi_mask_d;
         split_q     <= split_d;
         rsp_valid_q <= rsp_valid_d;
         ill_q       <= ill_d;
      end
   end

   // Next state; off_q only moves on accept, so a response leaving this cycle
   // is unaffected by a request accepted alongside it.
   always_comb begin
      state_d     = state_q;
      wa1_d       = wa1_q;
      off_d       = off_q;
      lo_d        = lo_q;
      hi_wdata_d  = hi_wdata_q;
      hi_mask_d   = hi_mask_q;
      split_d     = split_q;
      rsp_valid_d = 1'b0;
      ill_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               off_d   = off_s;
               wa1_d   = wa_s + {{(WA_W-1){1'b0}}, 1'b1};
               split_d = 1'b0;
               if (size_s == SZ_ILL) begin
                  rsp_valid_d = !i_req_we;
                  ill_d       = 1'b1;
               end else if (req_split_s) begin
                  state_d    = i_req_we ? ST2 : LD2;
                  hi_mask_d  = wmask8_s[7:4];
                  hi_wdata_d = wdata64_s[63:32];
               end else begin
                  rsp_valid_d = !i_req_we;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LD2: begin
            lo_d        = i_mem_rdata;
            split_d     = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         ST2: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SRAM strobes from the accepted request (beat 0) or the latched beat 1.
   always_comb begin
      o_req_ready = (state_q == IDLE) && i_rst_n;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = 32'h0000_0000;
      o_mem_bmask = 4'b0000;
      case (state_q)
         IDLE: begin
            if (accept_s && (size_s != SZ_ILL)) begin
               o_mem_en    = 1'b1;
               o_mem_we    = i_req_we;
               o_mem_addr  = wa_s;
               o_mem_wdata = wdata64_s[31:0];
               o_mem_bmask = i_req_we ? wmask8_s[3:0] : 4'b0000;
            end else begin
               o_mem_en = 1'b0;
            end
         end
         LD2: begin
            o_mem_en   = 1'b1;
            o_mem_addr = wa1_q;
         end
         ST2: begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = wa1_q;
            o_mem_wdata = hi_wdata_q;
            o_mem_bmask = hi_mask_q;
         end
         default: begin
            o_mem_en = 1'b0;
         end
      endcase
   end

   // Response realignment; SRAM data arrives in the response cycle itself.
   always_comb begin
      rsp_src_s   = split_q ? {i_mem_rdata, lo_q} : {32'h0000_0000, i_mem_rdata};
      rsp_shift_s = rsp_src_s >> {off_q, 3'b000};
      o_rsp_valid = rsp_valid_q;
      if (rsp_valid_q && !ill_q) begin
         o_rsp_data = rsp_shift_s[31:0];
      end else begin
         o_rsp_data = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl: a table of single-beat accesses plus
// hand-written split, wrap, back-to-back and reset sequences.
module tb_lsu_align_ctrl;
   import lsu_pkg::*;

   localparam int ADDR_W = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [15:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        mem_en, mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_bmask;
   logic [31:0] mem_rdata;

   logic        pre_we;
   logic [13:0] pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [0:16383];

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] cap;

   always #5 clk = ~clk;

   lsu_align_ctrl #(.ADDR_W(ADDR_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_size(req_size), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
   );

   // Word SRAM with byte writes and one-cycle read latency, plus a preload port.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (!rst_n) begin
         mem_rdata <= 32'h0;
      end else if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_bmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic        exp_en;
      logic [13:0] exp_addr;
      logic [3:0]  exp_mask;
      logic [31:0] exp_wdata;
      logic        exp_rsp;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mkv(input logic we, input logic [15:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, input logic en, input logic [13:0] ea,
                                input logic [3:0] m, input logic [31:0] ewd,
                                input logic rsp, input logic [31:0] ed);
      vec_t v;
      v.we = we; v.addr = a; v.size = sz; v.wdata = wd; v.exp_en = en; v.exp_addr = ea;
      v.exp_mask = m; v.exp_wdata = ewd; v.exp_rsp = rsp; v.exp_data = ed;
      return v;
   endfunction

   // Downstream load_unit extension model.
   function automatic logic [31:0] lu(input logic [31:0] d, input logic [1:0] sz, input logic uns);
      case (sz)
         2'b00:   lu = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   lu = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: lu = d;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [15:0] a, input logic [1:0] sz,
                        input logic [31:0] wd);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      drive(v.we, v.addr, v.size, v.wdata);
      @(negedge clk);
      chk({nm, "_ready"}, {31'h0, req_ready}, 32'h1);
      chk({nm, "_en"}, {31'h0, mem_en}, {31'h0, v.exp_en});
      if (v.exp_en) begin
         chk({nm, "_we"}, {31'h0, mem_we}, {31'h0, v.we});
         chk({nm, "_addr"}, {18'h0, mem_addr}, {18'h0, v.exp_addr});
         if (v.we) begin
            chk({nm, "_mask"}, {28'h0, mem_bmask}, {28'h0, v.exp_mask});
            chk({nm, "_wdata"}, mem_wdata, v.exp_wdata);
         end
      end
      idle();
      @(negedge clk);
      chk({nm, "_rspv"}, {31'h0, rsp_valid}, {31'h0, v.exp_rsp});
      if (v.exp_rsp) chk({nm, "_rspd"}, rsp_data, v.exp_data);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
      req_size = 2'b00; req_wdata = 32'h0; pre_we = 1'b0; pre_addr = 14'h0; pre_data = 32'h0;

      vecs[0]  = mkv(1'b0, 16'h0010, 2'b10, 32'h0,        1'b1, 14'h4, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF);
      vecs[1]  = mkv(1'b1, 16'h0010, 2'b10, 32'h80112233, 1'b1, 14'h4, 4'hF, 32'h80112233, 1'b0, 32'h0);
      vecs[2]  = mkv(1'b0, 16'h0013, 2'b00, 32'h0,        1'b1, 14'h4, 4'h0, 32'h0,        1'b1, 32'h00000080);
      vecs[3]  = mkv(1'b0, 16'h0012, 2'b01, 32'h0,        1'b1, 14'h4, 4'h0, 32'h0,        1'b1, 32'h00008011);
      vecs[4]  = mkv(1'b1, 16'h0011, 2'b00, 32'h000000AA, 1'b1, 14'h4, 4'h2, 32'h0000AA00, 1'b0, 32'h0);
      vecs[5]  = mkv(1'b0, 16'h0010, 2'b10, 32'h0,        1'b1, 14'h4, 4'h0, 32'h0,        1'b1, 32'h8011AA33);
      vecs[6]  = mkv(1'b1, 16'h0022, 2'b01, 32'h00001234, 1'b1, 14'h8, 4'hC, 32'h12340000, 1'b0, 32'h0);
      vecs[7]  = mkv(1'b0, 16'h0022, 2'b01, 32'h0,        1'b1, 14'h8, 4'h0, 32'h0,        1'b1, 32'h00001234);
      vecs[8]  = mkv(1'b0, 16'h0010, 2'b11, 32'h0,        1'b0, 14'h0, 4'h0, 32'h0,        1'b1, 32'h0);
      vecs[9]  = mkv(1'b1, 16'h0010, 2'b11, 32'hFFFFFFFF, 1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 32'h0);
      vecs[10] = mkv(1'b0, 16'h0007, 2'b00, 32'h0,        1'b1, 14'h1, 4'h0, 32'h0,        1'b1, 32'h000000AA);

      preload(14'h0004, 32'hDEADBEEF);
      preload(14'h0001, 32'hAABBCCDD);
      preload(14'h0002, 32'h11223344);
      preload(14'h0008, 32'h0);
      preload(14'h0000, 32'h0);
      preload(14'h3FFF, 32'h0);

      @(negedge clk);
      chk("rst_rspv", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rspd", rsp_data, 32'h0);
      chk("rst_en", {31'h0, mem_en}, 32'h0);
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_addr", {18'h0, mem_addr}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_mask", {28'h0, mem_bmask}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'h1);

      for (int i = 0; i < 11; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // LB of 0x80 through the load_unit model, signed and unsigned.
      drive(1'b0, 16'h0013, 2'b00, 32'h0);
      idle();
      @(negedge clk);
      cap = rsp_data;
      chk("lb_rspv", {31'h0, rsp_valid}, 32'h1);
      chk("lb_signed", lu(cap, 2'b00, 1'b0), 32'hFFFFFF80);
      chk("lbu", lu(cap, 2'b00, 1'b1), 32'h00000080);

      // Back-to-back loads; second accepted while the first responds.
      drive(1'b0, 16'h0010, 2'b10, 32'h0);
      @(negedge clk);
      chk("b2b_a_addr", {18'h0, mem_addr}, 32'h4);
      drive(1'b0, 16'h0004, 2'b10, 32'h0);
      @(negedge clk);
      chk("b2b_a_rspv", {31'h0, rsp_valid}, 32'h1);
      chk("b2b_a_rspd", rsp_data, 32'h8011AA33);
      chk("b2b_b_en", {31'h0, mem_en}, 32'h1);
      chk("b2b_b_addr", {18'h0, mem_addr}, 32'h1);
      chk("b2b_b_ready", {31'h0, req_ready}, 32'h1);
      idle();
      @(negedge clk);
      chk("b2b_b_rspv", {31'h0, rsp_valid}, 32'h1);
      chk("b2b_b_rspd", rsp_data, 32'hAABBCCDD);
      @(negedge clk);
      chk("b2b_end_rspv", {31'h0, rsp_valid}, 32'h0);

      // Split LW at 0x0006.
      drive(1'b0, 16'h0006, 2'b10, 32'h0);
      @(negedge clk);
      chk("slw_b0_en", {31'h0, mem_en}, 32'h1);
      chk("slw_b0_we", {31'h0, mem_we}, 32'h0);
      chk("slw_b0_addr", {18'h0, mem_addr}, 32'h1);
      idle();
      @(negedge clk);
      chk("slw_b1_ready", {31'h0, req_ready}, 32'h0);
      chk("slw_b1_en", {31'h0, mem_en}, 32'h1);
      chk("slw_b1_addr", {18'h0, mem_addr}, 32'h2);
      chk("slw_b1_rspv", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      chk("slw_rspv", {31'h0, rsp_valid}, 32'h1);
      chk("slw_rspd", rsp_data, 32'h3344AABB);
      chk("slw_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      chk("slw_end_rspv", {31'h0, rsp_valid}, 32'h0);

      // Split SH at 0x0007.
      drive(1'b1, 16'h0007, 2'b01, 32'h0000BEEF);
      @(negedge clk);
      chk("ssh_b0_addr", {18'h0, mem_addr}, 32'h1);
      chk("ssh_b0_mask", {28'h0, mem_bmask}, 32'h8);
      chk("ssh_b0_wdata", mem_wdata, 32'hEF000000);
      idle();
      @(negedge clk);
      chk("ssh_b1_ready", {31'h0, req_ready}, 32'h0);
      chk("ssh_b1_we", {31'h0, mem_we}, 32'h1);
      chk("ssh_b1_addr", {18'h0, mem_addr}, 32'h2);
      chk("ssh_b1_mask", {28'h0, mem_bmask}, 32'h1);
      chk("ssh_b1_wdata", mem_wdata, 32'h000000BE);
      @(negedge clk);
      chk("ssh_ready", {31'h0, req_ready}, 32'h1);
      chk("ssh_rspv", {31'h0, rsp_valid}, 32'h0);
      run_vec("ssh_w1", mkv(1'b0, 16'h0004, 2'b10, 32'h0, 1'b1, 14'h1, 4'h0, 32'h0, 1'b1, 32'hEFBBCCDD));
      run_vec("ssh_w2", mkv(1'b0, 16'h0008, 2'b10, 32'h0, 1'b1, 14'h2, 4'h0, 32'h0, 1'b1, 32'h112233BE));

      // Wrap-around SW at 0xFFFE and load it back.
      drive(1'b1, 16'hFFFE, 2'b10, 32'hCAFEF00D);
      @(negedge clk);
      chk("wrap_b0_addr", {18'h0, mem_addr}, 32'h3FFF);
      chk("wrap_b0_mask", {28'h0, mem_bmask}, 32'hC);
      chk("wrap_b0_wdata", mem_wdata, 32'hF00D0000);
      idle();
      @(negedge clk);
      chk("wrap_b1_addr", {18'h0, mem_addr}, 32'h0);
      chk("wrap_b1_mask", {28'h0, mem_bmask}, 32'h3);
      chk("wrap_b1_wdata", mem_wdata, 32'h0000CAFE);
      drive(1'b0, 16'hFFFE, 2'b10, 32'h0);
      @(negedge clk);
      chk("wrapld_b0_addr", {18'h0, mem_addr}, 32'h3FFF);
      idle();
      @(negedge clk);
      chk("wrapld_b1_addr", {18'h0, mem_addr}, 32'h0);
      @(negedge clk);
      chk("wrapld_rspv", {31'h0, rsp_valid}, 32'h1);
      chk("wrapld_rspd", rsp_data, 32'hCAFEF00D);

      // Reset while in LD2 abandons the access.
      drive(1'b0, 16'h0006, 2'b10, 32'h0);
      idle();
      @(negedge clk);
      chk("rld2_en_pre", {31'h0, mem_en}, 32'h1);
      chk("rld2_ready_pre", {31'h0, req_ready}, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("rld2_en", {31'h0, mem_en}, 32'h0);
      chk("rld2_rspv", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rld2_post_rspv", {31'h0, rsp_valid}, 32'h0);
      chk("rld2_post_en", {31'h0, mem_en}, 32'h0);
      chk("rld2_post_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      chk("rld2_post2_rspv", {31'h0, rsp_valid}, 32'h0);
      run_vec("rld2_lb", mkv(1'b0, 16'h0013, 2'b00, 32'h0, 1'b1, 14'h4, 4'h0, 32'h0, 1'b1, 32'h00000080));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
